// File: rtl/rv_mem_arb.sv
// Shares one single-port memory between instruction fetch and load/store,
// with a per-transaction timeout watchdog and a core stall output.
module rv_mem_arb #(
   parameter int unsigned TIMEOUT = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        if_req,
   input  logic [31:0] if_addr,
   output logic        if_rvalid,
   output logic [31:0] if_rdata,
   output logic        if_err,
   input  logic        dm_req,
   input  logic        dm_we,
   input  logic [31:0] dm_addr,
   input  logic [31:0] dm_wdata,
   input  logic [3:0]  dm_be,
   output logic        dm_rvalid,
   output logic [31:0] dm_rdata,
   output logic        dm_err,
   output logic        mem_req,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic [3:0]  mem_be,
   input  logic        mem_gnt,
   input  logic        mem_rvalid,
   input  logic [31:0] mem_rdata,
   output logic        stall,
   output logic        busy
);

   typedef enum logic [1:0] {
      IDLE,
      REQ,
      RESP,
      DONE
   } state_t;

   localparam logic [15:0] TLIM = 16'(TIMEOUT - 1);

   state_t      state;
   state_t      state_n;
   logic        owner_dm;
   logic [15:0] cnt;
   logic        take_dm;
   logic        take_if;
   logic        done_ok;
   logic        abort;
   logic        wd_hit;
   logic [31:0] resp_data;

   assign wd_hit    = (cnt >= TLIM);
   assign resp_data = mem_we ? 32'h0 : mem_rdata;

   // Core must hold while it has a request that is not completing this cycle.
   assign stall = (if_req | dm_req) & ~(if_rvalid | dm_rvalid);

   // Next-state logic; completion takes priority over a watchdog abort.
   always_comb begin
      state_n = state;
      take_dm = 1'b0;
      take_if = 1'b0;
      done_ok = 1'b0;
      abort   = 1'b0;
      unique case (state)
         IDLE: begin
            if (dm_req) begin
               take_dm = 1'b1;
               state_n = REQ;
            end else if (if_req) begin
               take_if = 1'b1;
               state_n = REQ;
            end
         end
         REQ: begin
            if (mem_gnt) begin
               state_n = RESP;
            end else if (wd_hit) begin
               abort   = 1'b1;
               state_n = DONE;
            end
         end
         RESP: begin
            if (mem_rvalid) begin
               done_ok = 1'b1;
               state_n = DONE;
            end else if (wd_hit) begin
               abort   = 1'b1;
               state_n = DONE;
            end
         end
         DONE: begin
            state_n = IDLE;
         end
         default: begin
            state_n = IDLE;
         end
      endcase
   end

   // State register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_n;
      end
   end

   // Request latches, watchdog counter and registered status outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         owner_dm  <= 1'b0;
         cnt       <= 16'h0;
         mem_req   <= 1'b0;
         mem_we    <= 1'b0;
         mem_addr  <= 32'h0;
         mem_wdata <= 32'h0;
         mem_be    <= 4'h0;
         busy      <= 1'b0;
      end else begin
         mem_req <= (state_n == REQ);
         busy    <= (state_n != IDLE);
         if (take_dm) begin
            owner_dm  <= 1'b1;
            mem_we    <= dm_we;
            mem_addr  <= dm_addr;
            mem_wdata <= dm_wdata;
            mem_be    <= dm_we ? dm_be : 4'h0;
         end else if (take_if) begin
            owner_dm  <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= {if_addr[31:2], 2'b00};
            mem_wdata <= 32'h0;
            mem_be    <= 4'h0;
         end
         if (take_dm || take_if) begin
            cnt <= 16'h0;
         end else if (state == REQ || state == RESP) begin
            cnt <= cnt + 16'd1;
         end
      end
   end

   // Completion pulses to the owning requester; read data holds between pulses.
   always_ff @(posedge clk) begin
      if (rst) begin
         if_rvalid <= 1'b0;
         if_rdata  <= 32'h0;
         if_err    <= 1'b0;
         dm_rvalid <= 1'b0;
         dm_rdata  <= 32'h0;
         dm_err    <= 1'b0;
      end else begin
         if_rvalid <= (done_ok | abort) & ~owner_dm;
         dm_rvalid <= (done_ok | abort) & owner_dm;
         if ((done_ok | abort) && !owner_dm) begin
            if_rdata <= abort ? 32'h0 : resp_data;
            if_err   <= abort;
         end
         if ((done_ok | abort) && owner_dm) begin
            dm_rdata <= abort ? 32'h0 : resp_data;
            dm_err   <= abort;
         end
      end
   end

endmodule

// File: tb/tb_rv_mem_arb.sv
// Directed bench for rv_mem_arb: default-timeout instance plus a
// TIMEOUT=4 instance for watchdog scenarios.
module tb_rv_mem_arb;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   ncmp = 0;
   int   nerr = 0;

   always #5 clk = ~clk;

   logic        if_req = 0, if_rvalid, if_err;
   logic [31:0] if_addr = 0, if_rdata;
   logic        dm_req = 0, dm_we = 0, dm_rvalid, dm_err;
   logic [31:0] dm_addr = 0, dm_wdata = 0, dm_rdata;
   logic [3:0]  dm_be = 0;
   logic        mem_req, mem_we, mem_gnt = 0, mem_rvalid = 0;
   logic [31:0] mem_addr, mem_wdata, mem_rdata = 0;
   logic [3:0]  mem_be;
   logic        stall, busy;

   logic        t_if_req = 0, t_if_rvalid, t_if_err;
   logic [31:0] t_if_addr = 0, t_if_rdata;
   logic        t_dm_req = 0, t_dm_we = 0, t_dm_rvalid, t_dm_err;
   logic [31:0] t_dm_addr = 0, t_dm_wdata = 0, t_dm_rdata;
   logic [3:0]  t_dm_be = 0;
   logic        t_mem_req, t_mem_we, t_mem_gnt = 0, t_mem_rvalid = 0;
   logic [31:0] t_mem_addr, t_mem_wdata, t_mem_rdata = 0;
   logic [3:0]  t_mem_be;
   logic        t_stall, t_busy;

   rv_mem_arb dut (
      .clk(clk), .rst(rst),
      .if_req(if_req), .if_addr(if_addr), .if_rvalid(if_rvalid),
      .if_rdata(if_rdata), .if_err(if_err),
      .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr),
      .dm_wdata(dm_wdata), .dm_be(dm_be), .dm_rvalid(dm_rvalid),
      .dm_rdata(dm_rdata), .dm_err(dm_err),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_be(mem_be), .mem_gnt(mem_gnt),
      .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
      .stall(stall), .busy(busy)
   );

   rv_mem_arb #(.TIMEOUT(4)) dut4 (
      .clk(clk), .rst(rst),
      .if_req(t_if_req), .if_addr(t_if_addr), .if_rvalid(t_if_rvalid),
      .if_rdata(t_if_rdata), .if_err(t_if_err),
      .dm_req(t_dm_req), .dm_we(t_dm_we), .dm_addr(t_dm_addr),
      .dm_wdata(t_dm_wdata), .dm_be(t_dm_be), .dm_rvalid(t_dm_rvalid),
      .dm_rdata(t_dm_rdata), .dm_err(t_dm_err),
      .mem_req(t_mem_req), .mem_we(t_mem_we), .mem_addr(t_mem_addr),
      .mem_wdata(t_mem_wdata), .mem_be(t_mem_be), .mem_gnt(t_mem_gnt),
      .mem_rvalid(t_mem_rvalid), .mem_rdata(t_mem_rdata),
      .stall(t_stall), .busy(t_busy)
   );

   task automatic cyc;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset;
      rst = 1'b1;
      cyc();
      cyc();
      ncmp++; if ({if_rvalid, if_err, dm_rvalid, dm_err} !== 4'h0) begin
         nerr++; $display("FAIL reset_flags got %b want 0000", {if_rvalid, if_err, dm_rvalid, dm_err}); end
      ncmp++; if ({mem_req, mem_we, busy, stall} !== 4'h0) begin
         nerr++; $display("FAIL reset_ctl got %b want 0000", {mem_req, mem_we, busy, stall}); end
      ncmp++; if (mem_addr !== 32'h0 || if_rdata !== 32'h0 || dm_rdata !== 32'h0) begin
         nerr++; $display("FAIL reset_data got %h/%h/%h want 0", mem_addr, if_rdata, dm_rdata); end
      rst = 1'b0;
      cyc();
   endtask

   task automatic test_fetch;
      logic dm_seen;
      dm_seen = 1'b0;
      if_req = 1; if_addr = 32'h0000_0013;
      #1;
      ncmp++; if (stall !== 1'b1) begin
         nerr++; $display("FAIL fetch_stall0 got %b want 1", stall); end
      cyc();
      dm_seen |= dm_rvalid;
      ncmp++; if (mem_req !== 1'b1 || mem_addr !== 32'h10) begin
         nerr++; $display("FAIL fetch_req got %b/%h want 1/00000010", mem_req, mem_addr); end
      ncmp++; if (mem_we !== 1'b0 || mem_be !== 4'h0) begin
         nerr++; $display("FAIL fetch_fields got %b/%h want 0/0", mem_we, mem_be); end
      mem_gnt = 1;
      cyc();
      dm_seen |= dm_rvalid;
      ncmp++; if (mem_req !== 1'b0 || if_rvalid !== 1'b0) begin
         nerr++; $display("FAIL fetch_c2 got %b/%b want 0/0", mem_req, if_rvalid); end
      mem_gnt = 0; mem_rvalid = 1; mem_rdata = 32'hDEAD_BEEF;
      cyc();
      dm_seen |= dm_rvalid;
      mem_rvalid = 0; mem_rdata = 32'h0;
      ncmp++; if (if_rvalid !== 1'b1 || if_rdata !== 32'hDEAD_BEEF || if_err !== 1'b0) begin
         nerr++; $display("FAIL fetch_rsp got %b/%h/%b want 1/deadbeef/0", if_rvalid, if_rdata, if_err); end
      ncmp++; if (stall !== 1'b0) begin
         nerr++; $display("FAIL fetch_stall3 got %b want 0", stall); end
      if_req = 0;
      cyc();
      dm_seen |= dm_rvalid;
      ncmp++; if (if_rvalid !== 1'b0 || busy !== 1'b0 || if_rdata !== 32'hDEAD_BEEF) begin
         nerr++; $display("FAIL fetch_c4 got %b/%b/%h want 0/0/deadbeef", if_rvalid, busy, if_rdata); end
      ncmp++; if (dm_seen !== 1'b0) begin
         nerr++; $display("FAIL fetch_dm_quiet got %b want 0", dm_seen); end
   endtask

   task automatic test_simul;
      dm_req = 1; dm_we = 1; dm_addr = 32'h10; dm_wdata = 32'hA5A5_A5A5; dm_be = 4'b0011;
      if_req = 1; if_addr = 32'h0000_0042;
      cyc();
      ncmp++; if (mem_req !== 1'b1 || mem_we !== 1'b1 || mem_be !== 4'h3) begin
         nerr++; $display("FAIL simul_st got %b/%b/%h want 1/1/3", mem_req, mem_we, mem_be); end
      ncmp++; if (mem_addr !== 32'h10 || mem_wdata !== 32'hA5A5_A5A5) begin
         nerr++; $display("FAIL simul_st_data got %h/%h want 10/a5a5a5a5", mem_addr, mem_wdata); end
      mem_gnt = 1;
      cyc();
      mem_gnt = 0; mem_rvalid = 1; mem_rdata = 32'h1234_5678;
      cyc();
      mem_rvalid = 0; mem_rdata = 32'h0;
      ncmp++; if (dm_rvalid !== 1'b1 || dm_rdata !== 32'h0 || dm_err !== 1'b0 || if_rvalid !== 1'b0) begin
         nerr++; $display("FAIL simul_dm_rsp got %b/%h/%b/%b want 1/0/0/0", dm_rvalid, dm_rdata, dm_err, if_rvalid); end
      dm_req = 0; dm_we = 0;
      cyc();
      ncmp++; if (mem_req !== 1'b0 || busy !== 1'b0 || stall !== 1'b1) begin
         nerr++; $display("FAIL simul_c4 got %b/%b/%b want 0/0/1", mem_req, busy, stall); end
      cyc();
      ncmp++; if (mem_req !== 1'b1 || mem_addr !== 32'h40 || mem_we !== 1'b0 || mem_be !== 4'h0) begin
         nerr++; $display("FAIL simul_if_req got %b/%h/%b/%h want 1/40/0/0", mem_req, mem_addr, mem_we, mem_be); end
      mem_gnt = 1;
      cyc();
      mem_gnt = 0; mem_rvalid = 1; mem_rdata = 32'hCAFE_F00D;
      cyc();
      mem_rvalid = 0; mem_rdata = 32'h0;
      ncmp++; if (if_rvalid !== 1'b1 || if_rdata !== 32'hCAFE_F00D || dm_rvalid !== 1'b0) begin
         nerr++; $display("FAIL simul_if_rsp got %b/%h/%b want 1/cafef00d/0", if_rvalid, if_rdata, dm_rvalid); end
      if_req = 0;
      cyc();
   endtask

   task automatic test_grant_stall;
      dm_req = 1; dm_we = 0; dm_addr = 32'h0000_0106; dm_wdata = 32'h55; dm_be = 4'hF;
      for (int i = 1; i <= 5; i++) begin
         cyc();
         ncmp++; if (mem_req !== 1'b1 || mem_addr !== 32'h106 || mem_be !== 4'h0 || mem_we !== 1'b0) begin
            nerr++; $display("FAIL gstall_hold c%0d got %b/%h/%h/%b want 1/106/0/0", i, mem_req, mem_addr, mem_be, mem_we); end
      end
      cyc();
      ncmp++; if (mem_req !== 1'b1 || mem_addr !== 32'h106) begin
         nerr++; $display("FAIL gstall_c6 got %b/%h want 1/106", mem_req, mem_addr); end
      mem_gnt = 1;
      cyc();
      mem_gnt = 0; mem_rvalid = 1; mem_rdata = 32'h0BAD_F00D;
      ncmp++; if (dm_rvalid !== 1'b0 || mem_req !== 1'b0) begin
         nerr++; $display("FAIL gstall_c7 got %b/%b want 0/0", dm_rvalid, mem_req); end
      cyc();
      mem_rvalid = 0; mem_rdata = 32'h0;
      ncmp++; if (dm_rvalid !== 1'b1 || dm_rdata !== 32'h0BAD_F00D || dm_err !== 1'b0) begin
         nerr++; $display("FAIL gstall_rsp got %b/%h/%b want 1/0badf00d/0", dm_rvalid, dm_rdata, dm_err); end
      dm_req = 0;
      cyc();
   endtask

   task automatic test_boundary;
      t_if_req = 1; t_if_addr = 32'h300;
      cyc();
      t_mem_gnt = 1;
      cyc();
      t_mem_gnt = 0;
      cyc();
      cyc();
      ncmp++; if (t_if_rvalid !== 1'b0 || t_busy !== 1'b1) begin
         nerr++; $display("FAIL bound_c4 got %b/%b want 0/1", t_if_rvalid, t_busy); end
      t_mem_rvalid = 1; t_mem_rdata = 32'h600D_DA7A;
      cyc();
      t_mem_rvalid = 0; t_mem_rdata = 32'h0;
      ncmp++; if (t_if_rvalid !== 1'b1 || t_if_err !== 1'b0 || t_if_rdata !== 32'h600D_DA7A) begin
         nerr++; $display("FAIL bound_rsp got %b/%b/%h want 1/0/600dda7a", t_if_rvalid, t_if_err, t_if_rdata); end
      t_if_req = 0;
      cyc();
   endtask

   task automatic test_timeout;
      t_if_req = 1; t_if_addr = 32'h200; t_mem_rdata = 32'hFFFF_FFFF;
      cyc();
      t_mem_gnt = 1;
      cyc();
      t_mem_gnt = 0;
      cyc();
      cyc();
      ncmp++; if (t_if_rvalid !== 1'b0 || t_busy !== 1'b1) begin
         nerr++; $display("FAIL tmo_c4 got %b/%b want 0/1", t_if_rvalid, t_busy); end
      cyc();
      ncmp++; if (t_if_rvalid !== 1'b1 || t_if_err !== 1'b1 || t_if_rdata !== 32'h0) begin
         nerr++; $display("FAIL tmo_rsp got %b/%b/%h want 1/1/0", t_if_rvalid, t_if_err, t_if_rdata); end
      t_if_req = 0;
      cyc();
      t_mem_rvalid = 1;
      cyc();
      t_mem_rvalid = 0;
      cyc();
      ncmp++; if ({t_busy, t_mem_req, t_if_rvalid, t_dm_rvalid} !== 4'h0) begin
         nerr++; $display("FAIL tmo_spurious got %b want 0000", {t_busy, t_mem_req, t_if_rvalid, t_dm_rvalid}); end
      t_dm_req = 1; t_dm_we = 0; t_dm_addr = 32'h400;
      cyc();
      cyc();
      cyc();
      cyc();
      ncmp++; if (t_mem_req !== 1'b1 || t_dm_rvalid !== 1'b0) begin
         nerr++; $display("FAIL tmo_req_c4 got %b/%b want 1/0", t_mem_req, t_dm_rvalid); end
      cyc();
      ncmp++; if (t_dm_rvalid !== 1'b1 || t_dm_err !== 1'b1 || t_dm_rdata !== 32'h0 || t_mem_req !== 1'b0) begin
         nerr++; $display("FAIL tmo_req_rsp got %b/%b/%h/%b want 1/1/0/0", t_dm_rvalid, t_dm_err, t_dm_rdata, t_mem_req); end
      t_dm_req = 0; t_mem_rdata = 32'h0;
      cyc();
   endtask

   task automatic test_reset_mid;
      logic seen;
      seen = 1'b0;
      if_req = 1; if_addr = 32'h500;
      cyc();
      mem_gnt = 1;
      cyc();
      mem_gnt = 0; rst = 1; if_req = 0;
      cyc();
      rst = 0; mem_rvalid = 1; mem_rdata = 32'h1111_1111;
      ncmp++; if (busy !== 1'b0 || mem_req !== 1'b0 || if_rvalid !== 1'b0) begin
         nerr++; $display("FAIL rstmid_c3 got %b/%b/%b want 0/0/0", busy, mem_req, if_rvalid); end
      cyc();
      seen |= if_rvalid;
      mem_rvalid = 0; mem_rdata = 32'h0;
      cyc();
      seen |= if_rvalid | busy;
      ncmp++; if (seen !== 1'b0) begin
         nerr++; $display("FAIL rstmid_quiet got %b want 0", seen); end
      if_req = 1; if_addr = 32'h604;
      cyc();
      ncmp++; if (mem_req !== 1'b1 || mem_addr !== 32'h604) begin
         nerr++; $display("FAIL rstmid_next_req got %b/%h want 1/604", mem_req, mem_addr); end
      mem_gnt = 1;
      cyc();
      mem_gnt = 0; mem_rvalid = 1; mem_rdata = 32'h0000_0077;
      cyc();
      mem_rvalid = 0; mem_rdata = 32'h0;
      ncmp++; if (if_rvalid !== 1'b1 || if_rdata !== 32'h77 || if_err !== 1'b0) begin
         nerr++; $display("FAIL rstmid_next_rsp got %b/%h/%b want 1/77/0", if_rvalid, if_rdata, if_err); end
      if_req = 0;
      cyc();
   endtask

   initial begin
      test_reset();
      test_fetch();
      test_simul();
      test_grant_stall();
      test_boundary();
      test_timeout();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
      $finish;
   end

endmodule

// File: doc/rv_mem_arb.md
# rv_mem_arb

Arbiter and sequencer that shares one single-port unified memory between the core's instruction-fetch path and its load/store path. It sits between the fetch/memory-access stages and the memory model, and serialises their requests through a req/gnt/rvalid memory handshake. It guards every transaction with a timeout watchdog and drives a stall signal the core uses to freeze its PC and register writeback.

## Interface
- TIMEOUT, 16: cycles a transaction may spend in REQ+RESP before it is aborted with an error; legal range 2..65535.
- clk  input  1  rising-edge clock.
- rst  input  1  reset; synchronous, active-high.
- if_req  input  1  fetch request; held high with if_addr stable until if_rvalid.
- if_addr  input  32  fetch byte address; bits [1:0] are ignored and forced to 0 on mem_addr.
- if_rvalid  output  1  one-cycle fetch completion pulse.
- if_rdata  output  32  fetched word; valid while if_rvalid is high, holds its value otherwise.
- if_err  output  1  fetch timed out; valid with if_rvalid.
- dm_req  input  1  data request; held high with the dm_* fields stable until dm_rvalid.
- dm_we  input  1  1 = store, 0 = load.
- dm_addr  input  32  data byte address, passed through unmodified.
- dm_wdata  input  32  store data.
- dm_be  input  4  store byte enables; forced to 4'b0000 on loads.
- dm_rvalid  output  1  one-cycle data completion pulse; issued for loads and stores.
- dm_rdata  output  32  load data; 0 for stores.
- dm_err  output  1  data access timed out; valid with dm_rvalid.
- mem_req  output  1  memory request.
- mem_we, mem_addr, mem_wdata, mem_be  output  1/32/32/4  request fields, stable while mem_req is high.
- mem_gnt  input  1  memory accepts the request in any cycle where mem_req and mem_gnt are both high.
- mem_rvalid  input  1  response strobe, also returned for writes.
- mem_rdata  input  32  response data.
- stall  output  1  core must hold state.
- busy  output  1  state is not IDLE.

## Operation
- FSM states: IDLE, REQ, RESP, DONE. Reset goes to IDLE.
- IDLE
  - If dm_req is high, latch the dm fields and set owner = DM. Data requests win because they belong to the older instruction.
  - Otherwise, if if_req is high, latch if_addr, set we = 0, be = 0, owner = IF.
  - Either case moves to REQ. With no request, stay in IDLE.
- REQ
  - mem_req = 1; mem_* fields come from the latched registers only.
  - On mem_gnt, go to RESP.
- RESP
  - mem_req = 0.
  - On mem_rvalid, capture mem_rdata (0 for stores) with err = 0, then go to DONE.
- DONE
  - Pulse the owner's rvalid for one cycle with the captured rdata and err. The other requester's rvalid stays 0.
  - Go to IDLE.
- Watchdog
  - Counter is cleared on IDLE→REQ and increments every cycle in REQ or RESP.
  - When the counter reaches TIMEOUT-1 and the current cycle does not complete the phase, the transaction is aborted: go to DONE with err = 1 and rdata = 0, and drop mem_req.
  - If completion and timeout happen in the same cycle, completion wins.
- mem_rvalid outside RESP is ignored and has no effect on state or outputs.
- A request still high in the cycle after its rvalid pulse is a new request.
- stall = (if_req | dm_req) & ~(if_rvalid | dm_rvalid).
- Reset mid-transaction returns to IDLE in the next cycle. The pending transaction is dropped and no rvalid is issued for it.

## Timing
- Reset values: every output is 0; internal latches and the counter are 0.
- All outputs are registered except stall, which is combinational from the inputs and registered rvalids.
- Minimum latency with gnt and rvalid each arriving at the earliest cycle:
  - req sampled at cycle 0
  - mem_req high at cycle 1, gnt at cycle 1
  - mem_rvalid at cycle 2
  - requester rvalid at cycle 3
- Back-to-back throughput: one transaction per 4 cycles minimum.
- Both requesting at cycle 0: DM is served first (dm_rvalid at cycle 3). IF is latched in IDLE at cycle 4, and if_rvalid arrives no earlier than cycle 7.
- The memory may hold mem_gnt low indefinitely; the timeout bounds this. mem_* fields do not change while mem_req is high.

## Test plan
- Fetch only: if_req, if_addr = 0x0000_0013, gnt at cycle 1, mem_rvalid at cycle 2 with 0xDEAD_BEEF.
  - Expect mem_addr = 0x0000_0010, if_rvalid at cycle 3, if_rdata = 0xDEAD_BEEF, if_err = 0, dm_rvalid = 0 throughout.
- Simultaneous requests: dm store 0x10→0xA5A5_A5A5 with be = 4'b0011, plus an if fetch.
  - Expect the first mem transaction to have we = 1 and be = 3, dm_rvalid at cycle 3 with dm_rdata = 0, the second transaction to be the fetch, and if_rvalid at cycle 7.
- Grant stall: gnt withheld 5 cycles. Expect mem_req and fields stable throughout, and rvalid 5 cycles later than minimum.
- Timeout, TIMEOUT = 4, no mem_rvalid ever.
  - Expect the abort after 4 cycles in REQ+RESP, owner rvalid with err = 1 and rdata = 0.
  - A later spurious mem_rvalid in IDLE is ignored.
- Completion at the timeout boundary: mem_rvalid in the exact cycle the counter reaches TIMEOUT-1. Expect err = 0 with the data delivered.
- Reset in RESP: assert rst for 1 cycle. Expect busy = 0 next cycle, no rvalid issued, and the next request served normally.
